// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10
  } state_e;

  // Counter value of the final (32nd) iteration step.
  localparam logic [5:0] LAST_STEP = 6'd31;

  // Two's-complement negate when neg is set; used for magnitudes and sign fixup.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    logic [DATA_W-1:0] r;
    if (neg) begin
      r = {DATA_W{1'b0}} - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// compare against the divisor, subtract when it fits, emit quotient bit.
module div_step
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic              next_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] trial_s;

  // Trial subtraction; the partial remainder stays below the divisor,
  // so the difference always fits in DATA_W bits.
  always_comb begin
    trial_s = {rem_in, next_bit};
    if (trial_s >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = trial_s[DATA_W-1:0] - divisor;
    end else begin
      q_bit   = 1'b0;
      rem_out = trial_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional build macro MULDIV_FAST_MULT_EN: multiplies complete combinationally
// in one cycle without asserting busy; divides stay iterative.
module muldiv_unit #(
  parameter int DATA_W = muldiv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              mthi,
  input  logic              mtlo,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  import muldiv_pkg::*;

  state_e              state_r;
  op_e                 op_r;
  logic [5:0]          cnt_r;
  logic [DATA_W-1:0]   a_raw_r;
  logic [DATA_W-1:0]   b_mag_r;
  logic                a_neg_r;
  logic                b_neg_r;
  logic [2*DATA_W-1:0] prod_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                busy_r;
  logic                done_r;
  logic                dbz_r;

  logic                in_signed_s;
  logic                a_neg_in_s;
  logic                b_neg_in_s;
  logic [DATA_W-1:0]   a_mag_in_s;
  logic [DATA_W-1:0]   b_mag_in_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W-1:0]   div_rem_s;
  logic                div_q_s;
  logic [2*DATA_W-1:0] step_next_s;
  logic [2*DATA_W-1:0] mul_fix_s;
  logic [DATA_W-1:0]   fix_hi_s;
  logic [DATA_W-1:0]   fix_lo_s;
  logic                fix_dbz_s;
  logic                fast_take_s;
  logic [2*DATA_W-1:0] fast_prod_s;

  // Operand sign capture and magnitude conversion at accept time.
  always_comb begin
    in_signed_s = ~op[0];
    a_neg_in_s  = in_signed_s & rs_val[DATA_W-1];
    b_neg_in_s  = in_signed_s & rt_val[DATA_W-1];
    a_mag_in_s  = cond_neg(rs_val, a_neg_in_s);
    b_mag_in_s  = cond_neg(rt_val, b_neg_in_s);
  end

`ifdef MULDIV_FAST_MULT_EN
  // Single-cycle multiply on sign-extended operands (low 64 bits are exact).
  always_comb begin
    fast_take_s = ~op[1];
    fast_prod_s = {{DATA_W{in_signed_s & rs_val[DATA_W-1]}}, rs_val} *
                  {{DATA_W{in_signed_s & rt_val[DATA_W-1]}}, rt_val};
  end
`else
  // Multiplies take the iterative path in this build.
  always_comb begin
    fast_take_s = 1'b0;
    fast_prod_s = {(2*DATA_W){1'b0}};
  end
`endif

  div_step u_div_step (
    .rem_in   (prod_r[2*DATA_W-1:DATA_W]),
    .next_bit (prod_r[DATA_W-1]),
    .divisor  (b_mag_r),
    .rem_out  (div_rem_s),
    .q_bit    (div_q_s)
  );

  // Next value of the shared product/remainder-quotient register for one step.
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]} + {1'b0, b_mag_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]};
    end
    if (op_r[1]) begin
      step_next_s = {div_rem_s, prod_r[DATA_W-2:0], div_q_s};
    end else begin
      step_next_s = {mul_sum_s, prod_r[DATA_W-1:1]};
    end
  end

  // Sign correction and divide-by-zero override for the final result.
  always_comb begin
    if (a_neg_r ^ b_neg_r) begin
      mul_fix_s = {(2*DATA_W){1'b0}} - prod_r;
    end else begin
      mul_fix_s = prod_r;
    end
    case (op_r)
      OP_DIV, OP_DIVU: begin
        if (b_mag_r == {DATA_W{1'b0}}) begin
          fix_hi_s  = a_raw_r;
          fix_lo_s  = {DATA_W{1'b1}};
          fix_dbz_s = 1'b1;
        end else begin
          fix_hi_s  = cond_neg(prod_r[2*DATA_W-1:DATA_W], a_neg_r);
          fix_lo_s  = cond_neg(prod_r[DATA_W-1:0], a_neg_r ^ b_neg_r);
          fix_dbz_s = 1'b0;
        end
      end
      OP_MULT, OP_MULTU: begin
        fix_hi_s  = mul_fix_s[2*DATA_W-1:DATA_W];
        fix_lo_s  = mul_fix_s[DATA_W-1:0];
        fix_dbz_s = 1'b0;
      end
      default: begin
        fix_hi_s  = {DATA_W{1'b0}};
        fix_lo_s  = {DATA_W{1'b0}};
        fix_dbz_s = 1'b0;
      end
    endcase
  end

  // Sequencer, iteration datapath and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= OP_MULT;
      cnt_r   <= 6'd0;
      a_raw_r <= {DATA_W{1'b0}};
      b_mag_r <= {DATA_W{1'b0}};
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      prod_r  <= {(2*DATA_W){1'b0}};
      hi_r    <= {DATA_W{1'b0}};
      lo_r    <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && fast_take_s) begin
            hi_r   <= fast_prod_s[2*DATA_W-1:DATA_W];
            lo_r   <= fast_prod_s[DATA_W-1:0];
            done_r <= 1'b1;
          end else if (start) begin
            op_r    <= op_e'(op);
            a_raw_r <= rs_val;
            a_neg_r <= a_neg_in_s;
            b_neg_r <= b_neg_in_s;
            b_mag_r <= b_mag_in_s;
            prod_r  <= {{DATA_W{1'b0}}, a_mag_in_s};
            cnt_r   <= 6'd0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            if (mthi) begin
              hi_r <= rs_val;
            end
            if (mtlo) begin
              lo_r <= rs_val;
            end
          end
        end
        ST_RUN: begin
          prod_r <= step_next_s;
          cnt_r  <= cnt_r + 6'd1;
          if (cnt_r == LAST_STEP) begin
            state_r <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          dbz_r   <= fix_dbz_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, q, r;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib;
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = {32'd0, a}; sb = {32'd0, b};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and collect what the DUT shows around completion.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit strobe,
                       output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                       output logic odbz, output bit busy_seen, output logic busy_at_done,
                       output int hold_viol, output logic tail);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; mthi = strobe; mtlo = strobe;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    lat = 1; busy_seen = 1'b0; hold_viol = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      if (hi !== m_hi || lo !== m_lo) hold_viol++;
      @(negedge clk);
      lat++;
    end
    ohi = hi; olo = lo; odbz = div_by_zero; busy_at_done = busy;
    @(negedge clk);
    tail = done | div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b11; rs_val = 32'hDEAD_BEEF; rt_val = 32'd1; mthi = 1'b1; mtlo = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_strobes();
    int lat, hv; logic [31:0] ohi, olo; logic odbz, bad, tl; bit bs;
    @(negedge clk); mtlo = 1'b1; rs_val = 32'h1234_5678;
    @(negedge clk); mtlo = 1'b0; m_lo = 32'h1234_5678;
    n_checks++; if (lo !== m_lo || hi !== m_hi) begin n_fail++; $display("FAIL mtlo_only: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    mthi = 1'b1; rs_val = 32'h0BAD_F00D;
    @(negedge clk); mthi = 1'b0; m_hi = 32'h0BAD_F00D;
    n_checks++; if (lo !== m_lo || hi !== m_hi) begin n_fail++; $display("FAIL mthi_only: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hAAAA_0000;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0; m_hi = 32'hAAAA_0000; m_lo = 32'hAAAA_0000;
    n_checks++; if (hi !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mthi_both: got %h want aaaa0000", hi); end
    n_checks++; if (lo !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mtlo_both: got %h want aaaa0000", lo); end
    do_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, ohi, olo, odbz, bs, bad, hv, tl);
    n_checks++; if (ohi !== 32'd1 || olo !== 32'd0) begin n_fail++; $display("FAIL multu_after_mt: got %h/%h want 1/0", ohi, olo); end
    n_checks++; if (lat !== ((FAST) ? 1 : 34)) begin n_fail++; $display("FAIL multu_after_mt_lat: got %0d want %0d", lat, (FAST) ? 1 : 34); end
    m_hi = 32'd1; m_lo = 32'd0;
    do_op(2'b10, 32'd100, 32'd7, 1'b1, lat, ohi, olo, odbz, bs, bad, hv, tl);
    n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL start_prio_hold: got %0d changed cycles want 0", hv); end
    n_checks++; if (ohi !== 32'd2 || olo !== 32'd14) begin n_fail++; $display("FAIL start_prio_div: got %h/%h want 2/e", ohi, olo); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  localparam int ND = 9;
  localparam logic [1:0]  D_OP [ND] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10};
  localparam logic [31:0] D_A  [ND] = '{32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h8000_0000,
                                       32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
  localparam logic [31:0] D_B  [ND] = '{32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF,
                                       32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE};
  localparam logic [31:0] D_HI [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'd0,
                                       32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h4000_0000, 32'd1};
  localparam logic [31:0] D_LO [ND] = '{32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000,
                                       32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD};
  localparam logic        D_DZ [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_directed();
    int lat, hv, exp_lat; logic [31:0] ohi, olo; logic odbz, bad, tl; bit bs, exp_bs;
    for (int i = 0; i < ND; i++) begin
      do_op(D_OP[i], D_A[i], D_B[i], 1'b0, lat, ohi, olo, odbz, bs, bad, hv, tl);
      exp_lat = (FAST && !D_OP[i][1]) ? 1 : 34;
      exp_bs  = !(FAST && !D_OP[i][1]);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_checks++; if (ohi !== D_HI[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, ohi, D_HI[i]); end
      n_checks++; if (olo !== D_LO[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, olo, D_LO[i]); end
      n_checks++; if (odbz !== D_DZ[i]) begin n_fail++; $display("FAIL dir%0d_dbz: got %b want %b", i, odbz, D_DZ[i]); end
      n_checks++; if (bs !== exp_bs) begin n_fail++; $display("FAIL dir%0d_busy_seen: got %b want %b", i, bs, exp_bs); end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, bad); end
      n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL dir%0d_hold: got %0d changed cycles want 0", i, hv); end
      n_checks++; if (tl !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse_width: got %b want 0", i, tl); end
      m_hi = D_HI[i]; m_lo = D_LO[i];
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    @(negedge clk); start = 1'b1; op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (done === 1'b1) done_cnt++;
      if (k == 4) begin start = 1'b1; mthi = 1'b1; rs_val = 32'h5555_5555; end
      if (k == 5) begin
        start = 1'b0; mthi = 1'b0;
        n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL abort_mthi_ignored: got %h want %h", hi, m_hi); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
      end
      if (k == 9) rst = 1'b1;
      if (k == 10) begin
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo); end
      end
      if (k < 10) @(negedge clk);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo_after: got %h/%h want 0/0", hi, lo); end
  endtask

  task automatic test_random();
    int lat, hv, exp_lat; logic [31:0] a, b, ohi, olo; logic [1:0] o; logic odbz, bad, tl; bit bs;
    logic [64:0] exp;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3)); a = pick(); b = pick();
      exp = model(o, a, b);
      do_op(o, a, b, 1'b0, lat, ohi, olo, odbz, bs, bad, hv, tl);
      exp_lat = (FAST && !o[1]) ? 1 : 34;
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, o, lat, exp_lat); end
      n_checks++; if (ohi !== exp[63:32] || olo !== exp[31:0])
        begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h/%h want %h/%h", i, o, a, b, ohi, olo, exp[63:32], exp[31:0]); end
      n_checks++; if (odbz !== exp[64]) begin n_fail++; $display("FAIL rnd%0d_dbz: got %b want %b", i, odbz, exp[64]); end
      n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL rnd%0d_hold: got %0d changed cycles want 0", i, hv); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_strobes();
    test_directed();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
